pattern_gen_chk: RTL
====================

# pattern_gen_chk

Parametrised test-pattern generator and loopback checker for board bring-up and datapath BIST. The generator drives a valid/ready stream carrying one of six selectable patterns. A burst is either counted or continuous until stopped. An independent checker regenerates the same sequence against a returning stream and counts mismatches. The block sits at the edge of a datapath under test: the TX stream feeds the path, and the RX stream is the path's output.

## Interface
- DATA_W, 32, stream word width (≥1)
- LEN_W, 16, burst length counter width
- ERR_W, 16, error counter width
- SEED, 32'h0000_0001, PRBS LFSR seed (must be nonzero)
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin burst; sampled in IDLE only
- stop  in  1  abort request; sampled in RUN only
- mode  in  3  pattern select, latched at start
- burst_len  in  LEN_W  beats per burst, latched at start; 0 = continuous
- tx_data  out  DATA_W  generated word
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accept
- tx_last  out  1  final beat of a counted burst
- rx_data  in  DATA_W  returned word
- rx_valid  in  1  rx_data valid (no backpressure)
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse on burst end
- err_count  out  ERR_W  mismatch count, saturating
- err_sticky  out  1  at least one mismatch since start

## Operation
- Modes:
  - 000 all-zero
  - 001 all-one
  - 010 alternate: first word 0x55…55, inverted each beat
  - 011 increment: first word 0, +1 mod 2^DATA_W
  - 100 walking-one: first word 1, rotate left 1 each beat; MSB wraps to bit 0
  - 101 PRBS: 32-bit Fibonacci LFSR s, next = {s[30:0], s[31]^s[21]^s[1]^s[0]}; word bit i = s[i mod 32]; first word = SEED
  - 110/111 behave as 000
- FSM IDLE → RUN → DONE → IDLE.
- IDLE: start=1 latches mode and burst_len, loads the first word into generator and checker, clears err_count and err_sticky, and moves to RUN.
- RUN: tx_valid=1. A handshake (tx_valid&tx_ready) advances the generator and the beat counter. tx_data is stable while tx_valid&!tx_ready.
- Counted burst: the handshake on beat burst_len-1 moves to DONE. tx_last=1 exactly on that beat.
- Continuous burst (burst_len=0): runs until stop. The beat counter wraps silently. tx_last is never asserted.
- stop=1 in RUN sets an abort pending. The next handshake, including one in the same cycle as stop, is the final beat, and the FSM moves to DONE. tx_last is not asserted on abort beats.
- The valid/ready hold rule is never violated, including on abort.
- DONE: done=1 for one cycle, then IDLE. start is ignored outside IDLE.
- Checker: keeps its own expected-word generator, reloaded at start with the same mode.
  - Each rx_valid compares rx_data to expected, then advances expected.
  - On a mismatch, err_count increments (saturating at all-ones) and err_sticky is set.
  - The checker runs regardless of FSM state; only start reloads it.
- Reset: state IDLE; tx_data, tx_valid, tx_last, busy, done, err_count, err_sticky all 0; LFSR copies = SEED; mode latch 000.

## Timing
- start sampled at edge N: tx_valid=1 with the first word from edge N, busy=1 from edge N.
- Throughput is one beat per cycle with tx_ready held high. The next word is registered on the handshake edge.
- Final handshake at edge M: tx_valid=0 and done=1 from edge M; IDLE from edge M+1.
- A start in the cycle after done is accepted.
- rx beat at edge K: err_count and err_sticky reflect it from edge K. Checker latency is 1 cycle, with no pipeline beyond that.
- rst_n low mid-burst: all outputs return to reset values immediately (asynchronously). No done pulse is produced.

## Test plan
- mode=011, burst_len=4, tx_ready=1 → tx_data 0,1,2,3 on 4 consecutive cycles; tx_last on 3; done one cycle after; busy low after.
- mode=010, burst_len=3, tx_ready toggling 1,0,1,0,1 → 0x55555555, 0xAAAAAAAA, 0x55555555; data held during ready=0.
- mode=100, DATA_W=8, burst_len=10 → 0x01,0x02,…,0x80,0x01,0x02 (wrap).
- mode=101, burst_len=0, stop at beat 5 with tx_ready=0, ready asserted 2 cycles later → exactly 6 beats; first = SEED; no tx_last; done pulses once.
- rx looped to tx, mode=101, 100 beats, one rx word bit-flipped at beat 40 → err_count=1, err_sticky=1; next start clears both.
- ERR_W=4, rx_data forced 0 against mode=001 for 20 beats → err_count saturates at 15; rst_n pulse mid-burst → all outputs 0, no done.

Source files
------------

// File: rtl/pattern_gen_chk.sv
// Test-pattern generator (valid/ready TX stream) with an independent loopback checker
// that regenerates the same pattern sequence against the returning RX stream.
module pattern_gen_chk #(
    parameter int          DATA_W = 32,
    parameter int          LEN_W  = 16,
    parameter int          ERR_W  = 16,
    parameter logic [31:0] SEED   = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [2:0]        mode,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic              err_sticky,
    output logic [1:0]        dbg_state
);

    // TX handshake: a beat transfers on any rising edge where tx_valid && tx_ready;
    // once tx_valid is high it stays high with tx_data frozen until that transfer.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [DATA_W-1:0] chk_word_q, chk_word_d;
    logic [31:0]       chk_lfsr_q, chk_lfsr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              sticky_q, sticky_d;
    logic              hs, last_beat;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_word(input logic [31:0] s);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W; i++) w[i] = s[i % 32];
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] first_word(input logic [2:0] m);
        logic [DATA_W-1:0] w;
        w = '0;
        case (m)
            3'b001: w = '1;
            3'b010: for (int i = 0; i < DATA_W; i++) w[i] = ((i % 2) == 0);
            3'b100: w = DATA_W'(1);
            3'b101: w = lfsr_word(SEED);
            default: w = '0;
        endcase
        return w;
    endfunction

    // s_next is the already-advanced LFSR, so PRBS words track the register copy.
    function automatic logic [DATA_W-1:0] next_word(input logic [2:0] m,
                                                    input logic [DATA_W-1:0] w,
                                                    input logic [31:0] s_next);
        logic [DATA_W-1:0] n;
        n = '0;
        case (m)
            3'b001: n = '1;
            3'b010: n = ~w;
            3'b011: n = w + DATA_W'(1);
            3'b100: n = (w << 1) | (w >> (DATA_W - 1));
            3'b101: n = lfsr_word(s_next);
            default: n = '0;
        endcase
        return n;
    endfunction

    assign tx_valid   = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign hs         = tx_valid & tx_ready;
    assign last_beat  = (len_q != '0) && (beat_q == len_q - LEN_W'(1));
    assign tx_last    = tx_valid & last_beat & ~abort_q;
    assign tx_data    = data_q;
    assign err_count  = err_q;
    assign err_sticky = sticky_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        beat_d     = beat_q;
        abort_d    = abort_q;
        data_d     = data_q;
        lfsr_d     = lfsr_q;
        chk_word_d = chk_word_q;
        chk_lfsr_d = chk_lfsr_q;
        err_d      = err_q;
        sticky_d   = sticky_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    len_d   = burst_len;
                    beat_d  = '0;
                    abort_d = 1'b0;
                    data_d  = first_word(mode);
                    lfsr_d  = SEED;
                end
            end
            S_RUN: begin
                if (stop) abort_d = 1'b1;
                if (hs) begin
                    beat_d = beat_q + LEN_W'(1);
                    lfsr_d = lfsr_step(lfsr_q);
                    data_d = next_word(mode_q, data_q, lfsr_d);
                    if (last_beat || stop || abort_q) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Checker free-runs on rx_valid; only an accepted start reloads it.
        if (state_q == S_IDLE && start) begin
            chk_word_d = first_word(mode);
            chk_lfsr_d = SEED;
            err_d      = '0;
            sticky_d   = 1'b0;
        end else if (rx_valid) begin
            if (rx_data != chk_word_q) begin
                sticky_d = 1'b1;
                if (err_q != '1) err_d = err_q + ERR_W'(1);
            end
            chk_lfsr_d = lfsr_step(chk_lfsr_q);
            chk_word_d = next_word(mode_q, chk_word_q, chk_lfsr_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 3'b000;
            len_q      <= '0;
            beat_q     <= '0;
            abort_q    <= 1'b0;
            data_q     <= '0;
            lfsr_q     <= SEED;
            chk_word_q <= '0;
            chk_lfsr_q <= SEED;
            err_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            abort_q    <= abort_d;
            data_q     <= data_d;
            lfsr_q     <= lfsr_d;
            chk_word_q <= chk_word_d;
            chk_lfsr_q <= chk_lfsr_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
        end
    end

endmodule
